// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types, digit limits and the seven-segment decoder.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

  localparam logic [3:0] TENTHS_MAX   = 4'd9;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] MIN_ONES_MAX = 4'd9;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioning: 2-FF synchronizer, stable-count debouncer and
// a registered falling-edge detector giving one press pulse per accepted press.
module key_debounce import stopwatch_pkg::*; #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] count;

  // Levels reset to "released" so a key held through reset still yields one press.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      count   <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (count == CNT_LAST) begin
          level <= sync2;
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end else begin
        count <= '0;
      end
      level_d <= level;
      press   <= level_d & ~level;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/clear keys drive a M:SS.t counter
// advanced by a 10 Hz tick, with a lap hold register and registered HEX outputs.
module stopwatch_ctrl import stopwatch_pkg::*; #(
  parameter int FREQ      = 50_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       key_ss,
  input  logic       key_lc,
  output logic       run,
  output logic       lap,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  localparam int TICK_DIV = FREQ / 10;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t            state;
  logic              p_ss;
  logic              p_lc;
  logic              counting;
  logic              tick;
  logic              clear;
  logic              capture;
  logic [PRE_W-1:0]  prescaler;
  logic [3:0]        tenths;
  logic [3:0]        sec_ones;
  logic [3:0]        sec_tens;
  logic [3:0]        min_ones;
  logic [15:0]       live_digits;
  logic [15:0]       lap_digits;
  logic [15:0]       shown;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_ss (
    .clk   (clk),
    .n_rst (n_rst),
    .key_n (key_ss),
    .press (p_ss)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_lc (
    .clk   (clk),
    .n_rst (n_rst),
    .key_n (key_lc),
    .press (p_lc)
  );

  assign counting    = (state == RUN) || (state == LAP);
  assign tick        = counting && (prescaler == PRE_LAST);
  assign clear       = (state == PAUSE) && p_lc && !p_ss;
  assign capture     = (state == RUN) && p_lc && !p_ss;
  assign run         = counting;
  assign lap         = (state == LAP);
  assign live_digits = {min_ones, sec_tens, sec_ones, tenths};
  assign shown       = (state == LAP) ? lap_digits : live_digits;

  // Start/stop has priority whenever both presses arrive in the same cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (p_ss) state <= RUN;
        RUN:     if (p_ss) state <= PAUSE; else if (p_lc) state <= LAP;
        LAP:     if (p_ss) state <= PAUSE; else if (p_lc) state <= RUN;
        PAUSE:   if (p_ss) state <= RUN;   else if (p_lc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A tick on the cycle that leaves RUN/LAP still lands, since it follows the current state.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      prescaler <= '0;
      tenths    <= '0;
      sec_ones  <= '0;
      sec_tens  <= '0;
      min_ones  <= '0;
    end else if (counting) begin
      if (!tick) begin
        prescaler <= prescaler + 1'b1;
      end else begin
        prescaler <= '0;
        if (tenths != TENTHS_MAX) begin
          tenths <= tenths + 4'd1;
        end else begin
          tenths <= '0;
          if (sec_ones != SEC_ONES_MAX) begin
            sec_ones <= sec_ones + 4'd1;
          end else begin
            sec_ones <= '0;
            if (sec_tens != SEC_TENS_MAX) begin
              sec_tens <= sec_tens + 4'd1;
            end else begin
              sec_tens <= '0;
              min_ones <= (min_ones == MIN_ONES_MAX) ? 4'd0 : min_ones + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      lap_digits <= '0;
    end else if (capture) begin
      lap_digits <= live_digits;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      HEX3 <= SEG_ZERO;
      HEX2 <= SEG_ZERO;
      HEX1 <= SEG_ZERO;
      HEX0 <= SEG_ZERO;
    end else begin
      HEX3 <= seg7(shown[15:12]);
      HEX2 <= seg7(shown[11:8]);
      HEX1 <= seg7(shown[7:4]);
      HEX0 <= seg7(shown[3:0]);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized key stimulus against an elapsed-time reference model of the stopwatch;
// every cycle the DUT outputs are compared with the model's expected display.
module tb_stopwatch_ctrl;

  localparam int FREQ     = 100;
  localparam int DB       = 4;
  localparam int TICK_DIV = FREQ / 10;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_LAP    = 3;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       key_ss = 1'b1;
  logic       key_lc = 1'b1;
  logic       run;
  logic       lap;
  logic [6:0] hex3, hex2, hex1, hex0;

  int n_vec = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  int m_edge = 0;
  int m_mode = M_IDLE;
  int m_n = 0;
  int m_lap = 0;
  int ss_q[$];
  int lc_q[$];
  bit m_pss, m_plc;
  int m_shown;
  logic [6:0] e_h3 = 7'h40, e_h2 = 7'h40, e_h1 = 7'h40, e_h0 = 7'h40;

  stopwatch_ctrl #(.FREQ(FREQ), .DB_CYCLES(DB)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .key_ss (key_ss),
    .key_lc (key_lc),
    .run    (run),
    .lap    (lap),
    .HEX3   (hex3),
    .HEX2   (hex2),
    .HEX1   (hex1),
    .HEX0   (hex0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segRef(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: elapsed tenths = RUN/LAP cycles / TICK_DIV, wrapping at 10 minutes.
  initial begin
    forever begin
      @(posedge clk);
      m_edge++;
      m_pss = 1'b0;
      m_plc = 1'b0;
      if (ss_q.size() > 0 && ss_q[0] == m_edge) begin m_pss = 1'b1; void'(ss_q.pop_front()); end
      if (lc_q.size() > 0 && lc_q[0] == m_edge) begin m_plc = 1'b1; void'(lc_q.pop_front()); end
      if (!n_rst) begin
        m_mode = M_IDLE;
        m_n = 0;
        m_lap = 0;
        ss_q.delete();
        lc_q.delete();
        e_h3 = 7'h40; e_h2 = 7'h40; e_h1 = 7'h40; e_h0 = 7'h40;
      end else begin
        m_shown = (m_mode == M_LAP) ? m_lap : (m_n / TICK_DIV) % 6000;
        e_h0 = segRef(m_shown % 10);
        e_h1 = segRef((m_shown / 10) % 10);
        e_h2 = segRef((m_shown / 100) % 6);
        e_h3 = segRef((m_shown / 600) % 10);
        if (m_mode == M_RUN && m_plc && !m_pss) m_lap = (m_n / TICK_DIV) % 6000;
        if (m_mode == M_RUN || m_mode == M_LAP) m_n++;
        case (m_mode)
          M_IDLE:  if (m_pss) m_mode = M_RUN;
          M_RUN:   if (m_pss) m_mode = M_PAUSE; else if (m_plc) m_mode = M_LAP;
          M_LAP:   if (m_pss) m_mode = M_PAUSE; else if (m_plc) m_mode = M_RUN;
          default: if (m_pss) m_mode = M_RUN;
                   else if (m_plc) begin m_mode = M_IDLE; m_n = 0; end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en)
        checkOutput("outs", 32'({run, lap, hex3, hex2, hex1, hex0}),
                    32'({(m_mode == M_RUN || m_mode == M_LAP), (m_mode == M_LAP), e_h3, e_h2, e_h1, e_h0}));
    end
  end

  // kind: 0 start/stop, 1 lap/clear, 2 both together, 3 start/stop bounce.
  task automatic applyStimulus(input int kind, input int hold, input int gap, output int due);
    @(negedge clk);
    due = m_edge + 1 + DB + 3;
    case (kind)
      0: begin key_ss = 1'b0; ss_q.push_back(due); end
      1: begin key_lc = 1'b0; lc_q.push_back(due); end
      2: begin key_ss = 1'b0; key_lc = 1'b0; ss_q.push_back(due); lc_q.push_back(due); end
      default: due = 0;
    endcase
    if (kind == 3) begin
      for (int i = 0; i < 5; i++) begin
        key_ss = 1'b0;
        repeat (2) @(negedge clk);
        key_ss = 1'b1;
        repeat (2) @(negedge clk);
      end
    end else begin
      repeat (hold) @(negedge clk);
      key_ss = 1'b1;
      key_lc = 1'b1;
    end
    repeat (DB + 3 + gap) @(negedge clk);
  endtask

  initial begin
    int due;
    int guard;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    n_rst = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("rst_hex", 32'({hex3, hex2, hex1, hex0}), 32'({4{7'h40}}));
    checkOutput("rst_run", 32'(run), 32'd0);

    applyStimulus(0, 5, 0, due);
    guard = 0;
    while (m_edge < due + 101 && guard < 500) begin @(negedge clk); guard++; end
    checkOutput("one_sec_hex", 32'({run, hex1, hex0}), 32'({1'b1, 7'h79, 7'h40}));

    applyStimulus(0, DB, 3, due);
    applyStimulus(1, DB, 3, due);
    applyStimulus(3, 0, 10, due);
    checkOutput("bounce_run", 32'(run), 32'd0);

    applyStimulus(0, DB, 0, due);
    guard = 0;
    while (m_n < 340 && guard < 2000) begin @(negedge clk); guard++; end
    applyStimulus(1, 5, 0, due);
    checkOutput("lap_frozen", 32'({lap, hex3, hex2, hex1, hex0}), 32'({1'b1, 7'h40, 7'h40, 7'h30, 7'h19}));
    repeat (50) @(negedge clk);
    checkOutput("lap_held", 32'({lap, hex3, hex2, hex1, hex0}), 32'({1'b1, 7'h40, 7'h40, 7'h30, 7'h19}));
    applyStimulus(1, DB, 5, due);

    applyStimulus(0, DB, 0, due);
    repeat (500) @(negedge clk);
    applyStimulus(1, DB, 0, due);
    checkOutput("clear_hex", 32'({run, hex3, hex2, hex1, hex0}), 32'({1'b0, {4{7'h40}}}));

    applyStimulus(0, DB, 20, due);
    applyStimulus(0, DB, 5, due);
    applyStimulus(2, DB, 0, due);
    checkOutput("both_keys", 32'({run, lap}), 32'b10);

    for (int k = 0; k < 16; k++)
      applyStimulus($urandom_range(0, 3), $urandom_range(DB, DB + 6), $urandom_range(0, 30), due);

    for (int k = 0; k < 4 && m_mode != M_IDLE; k++)
      applyStimulus((m_mode == M_PAUSE) ? 1 : 0, DB, 0, due);
    checkOutput("to_idle", 32'({run, hex3, hex2, hex1, hex0}), 32'({1'b0, {4{7'h40}}}));

    applyStimulus(0, DB, 0, due);
    guard = 0;
    while (m_n < 59980 && guard < 70000) begin @(negedge clk); guard++; end
    @(negedge clk);
    checkOutput("pre_wrap", 32'({hex3, hex2, hex1, hex0}), 32'({7'h10, 7'h12, 7'h10, 7'h00}));
    guard = 0;
    while (m_n < 60000 && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    checkOutput("wrap_zero", 32'({run, hex3, hex2, hex1, hex0}), 32'({1'b1, {4{7'h40}}}));

    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_reset", 32'({run, lap, hex3, hex2, hex1, hex0}), 32'({2'b00, {4{7'h40}}}));
    n_rst = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch controller that sequences a tenths-of-a-second counting datapath from two push-buttons and drives four seven-segment digits. It generates a 10 Hz tick from `clk`. It runs a start/stop/lap/clear state machine and owns the M:SS.t digit counters. It sits between the board keys and the HEX displays, as the next step up from the free-running 1 Hz single-digit counter.

## Interface
- `FREQ`, 50_000_000, clk frequency in Hz; must be a multiple of 10 and ≥ 10; TICK_DIV = FREQ/10.
- `DB_CYCLES`, 1_000_000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz); ≥ 1.
- `clk`  in  1  clock.
- `n_rst`  in  1  reset: synchronous, active-low.
- `key_ss`  in  1  raw start/stop key, active-low (pressed = 0), asynchronous to clk.
- `key_lc`  in  1  raw lap/clear key, active-low, asynchronous to clk.
- `run`  out  1  high in RUN and LAP.
- `lap`  out  1  high in LAP.
- `HEX3`  out  7  minutes ones, active-low segments {g,f,e,d,c,b,a}.
- `HEX2`  out  7  seconds tens (0–5).
- `HEX1`  out  7  seconds ones (0–9).
- `HEX0`  out  7  tenths (0–9).

## Operation
- Key path:
  - Each key passes through a 2-FF synchronizer, then a debouncer, then a falling-edge detector.
  - The result is a one-cycle press pulse (`p_ss`, `p_lc`).
  - Release produces no pulse.
- FSM states: IDLE, RUN, PAUSE, LAP.
- IDLE:
  - `p_ss` → RUN.
  - `p_lc` ignored.
- RUN:
  - `p_ss` → PAUSE.
  - `p_lc` → LAP; the lap register captures the live digits in the same edge.
- LAP:
  - Counting continues; the display shows the lap register.
  - `p_lc` → RUN (display live again).
  - `p_ss` → PAUSE (display live).
- PAUSE:
  - `p_ss` → RUN.
  - `p_lc` → IDLE; digits and prescaler clear to 0.
- Simultaneous `p_ss` and `p_lc` in one cycle: `p_ss` acts, `p_lc` is discarded.
- Prescaler:
  - 0..TICK_DIV-1; increments only in RUN/LAP; holds in PAUSE; 0 in IDLE.
  - `tick` = (prescaler == TICK_DIV-1) while in RUN/LAP; the prescaler wraps to 0 on that cycle.
- Digit chain on tick:
  - tenths 0–9, carry to sec ones 0–9, carry to sec tens 0–5, carry to min ones 0–9.
  - 9:59.9 → 0:00.0, free wrap, no flag.
- Leaving RUN/LAP to PAUSE on the same cycle as `tick`: the tick still applies.
- Digits 0–9 are decoded to standard patterns (0 = 7'b1000000). Out-of-range codes are unreachable; blank (7'h7F) if forced.

## Timing
- Reset values:
  - state IDLE, prescaler and all digits 0, lap register 0.
  - sync and debounced levels 1 (released), counters 0.
  - `run`=0, `lap`=0, HEX0–3 = 7'b1000000.
- Reset mid-count behaves identically and returns to IDLE on the reset edge; no pulse is generated by reset.
- A key held low through reset deasserts as released and then produces one press after debounce.
- Debounce counter:
  - Counts while the synchronized level ≠ the debounced level.
  - Clears on any cycle they match.
  - The debounced level flips when the count reaches DB_CYCLES-1 with the mismatch still present.
- Press latency: a key first sampled low at edge t yields the press pulse high during cycle t+DB_CYCLES+2. The FSM state changes at edge t+DB_CYCLES+3.
- Bounce shorter than DB_CYCLES stable cycles produces no pulse.
- Tick cadence: exactly one tick per TICK_DIV cycles of RUN/LAP time. Pause time is excluded (prescaler holds).
- Outputs are registered: HEX reflects digit/state changes one cycle after the edge that changes them. `run`/`lap` are direct state decodes.

## Structure
- `stopwatch_pkg`:
  - `state_t` enum {IDLE, RUN, PAUSE, LAP}.
  - Digit limits (9, 5, 9, 9).
  - `SEG_BLANK` and the seg7 pattern function `seg7(input [3:0])`.
- Sub-module `key_debounce` (params `DB_CYCLES`; ports `clk`, `n_rst`, `key_n`, `press`), instantiated twice.
- Prescaler, digit chain, lap register and FSM stay in `stopwatch_ctrl`.

## Test plan
Bench parameters: FREQ=100 (TICK_DIV=10), DB_CYCLES=4.
- Reset, no keys → HEX3..0 all 7'b1000000, `run`=0, state IDLE for 50 cycles.
- `key_ss` low at edge t → `p_ss` high in cycle t+6 only; RUN from edge t+7; after 100 cycles HEX0 = digit 0 with carry, HEX1 = 1 (10 ticks).
- `key_ss` bouncing 0/1 every 2 cycles for 20 cycles then released → no state change.
- RUN, press `key_lc` at displayed 0:03.4 → `lap`=1, display frozen at 0:03.4 while the internal count advances. Press `key_lc` again → live count shown.
- RUN → PAUSE for 500 cycles → digits and prescaler unchanged. Press `key_lc` → IDLE, all digits 0. Both keys in the same debounced cycle from PAUSE → RUN only.
- Preload to 9:59.8, run 20 cycles → 9:59.9 then 0:00.0. Assert `n_rst` mid-prescale → IDLE, all outputs at reset values next cycle.
